stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Registered 1:N stream demultiplexer; the routing counterpart of the mux2_1/mux4_1/mux8_1 select trees.
- Accepts one data word per cycle on a valid/ready input and steers it to one of N output channels chosen by a select field.
- Each output channel has its own holding register and valid/ready handshake.
- Used to fan results out to per-unit consumers, for example routing writeback data to destination stages.

Parameters:
- N, 6, number of output channels (2..16); need not be a power of two.
- W, 32, data width in bits.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid & in_ready
- in_sel  input  SEL_W  destination channel index
- in_data  input  W  input word
- out_valid  output  N  per-channel word held
- out_ready  input  N  per-channel consumer accepts
- out_data  output  N*W  channel i data on out_data[i*W +: W]
- err  output  1  present only with STREAM_DEMUX_ERR_EN; see Optional Feature

Behaviour:
- Reset (asynchronous, any cycle):
  - out_valid = 0 and out_data = 0 for every channel.
  - Any held word is discarded.
  - err = 0.
- Input accept:
  - For a legal select (in_sel < N), in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - in_ready is combinational from in_sel, out_valid and out_ready only. It never depends on in_valid, so there is no combinational loop.
- Load:
  - On an accepted transfer, at that clock edge: slot[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency is exactly 1 cycle, input handshake to out_valid.
- Drain:
  - On out_valid[i] & out_ready[i] with no new load to i, out_valid[i] <= 0 at the edge.
  - out_data[i] keeps its last value; it is don't-care while invalid but must not glitch while valid.
- Simultaneous drain and load on the same channel:
  - The slot reloads with the new word and out_valid[i] stays 1.
  - Full throughput is 1 word per cycle per channel.
- Independence:
  - Channels not addressed by the input are unaffected by the input handshake.
  - A stalled channel (out_ready low) blocks only inputs targeting that channel.
- Stability:
  - While out_valid[i] & ~out_ready[i], out_data[i] holds constant.
- Out-of-range select (in_sel >= N):
  - in_ready = 1 and the word is dropped; no slot changes.
- Reset mid-operation:
  - Held words are lost.
  - in_ready may be high during reset, but no transfer is registered while reset is asserted.
- Ordering:
  - Words to the same channel leave in acceptance order.
  - There is no ordering guarantee across channels.

Optional Feature:
- Macro: STREAM_DEMUX_ERR_EN.
- Defined:
  - The err port exists.
  - err is registered high for exactly one cycle following any accepted transfer with in_sel >= N, and is otherwise 0.
  - The word is still dropped.
- Not defined:
  - No err port and no err register.
  - Illegal selects are silently dropped.
  - When N is a power of two, this case cannot occur.

Decomposition:
- Package stream_demux_pkg holds:
  - default constants DEMUX_N_DEF = 6 and DEMUX_W_DEF = 32;
  - function sel_width(n), which returns ceil(log2(n)) with a minimum of 1.
- Sub-module stream_demux_slot, instantiated N times via generate:
  - contents: one W-bit holding register with valid flag;
  - inputs: load, load_data, out_ready;
  - outputs: out_valid, out_data, can_accept.
- Top level does select decode, in_ready selection and the illegal-select check.

Test Plan:
- Reset release, all out_ready = 0 -> out_valid = 000000 and in_ready = 1 for in_sel = 0.
- Load 0xA5A5_0001 to ch2 with out_ready[2] = 0 -> next cycle out_valid = 000100 and ch2 data = 0xA5A5_0001. A second word to ch2 then sees in_ready = 0 and the held data is unchanged.
- Same channel, back to back, out_ready[2] = 1: send 0x11, 0x22, 0x33 on consecutive cycles -> in_ready stays 1 and ch2 outputs 0x11, 0x22, 0x33 on consecutive cycles.
- ch1 stalled holding 0x77: a word 0x88 to ch4 is accepted immediately -> ch4 valid next cycle while ch1 still holds 0x77.
- in_sel = 7 with in_valid = 1 -> in_ready = 1 and out_valid unchanged. With STREAM_DEMUX_ERR_EN, err = 1 for exactly one cycle.
- Assert reset while ch0, ch3 and ch5 are valid -> out_valid = 000000 immediately, without waiting for clk; after release, a fresh load to ch3 works with 1-cycle latency.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared defaults and the select-width helper for the stream_demux block.
// Optional error reporting is controlled by STREAM_DEMUX_ERR_EN (see stream_demux.sv).
package stream_demux_pkg;

  localparam int DEMUX_N_DEF = 6;
  localparam int DEMUX_W_DEF = 32;

  // ceil(log2(n)), never less than 1 so a 2-channel demux still has a select bit
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel of stream_demux: a holding register with a valid flag.
// A load in the same cycle as a drain wins, so the channel sustains one word per cycle.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W = DEMUX_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         can_accept
);

  assign can_accept = ~out_valid | out_ready;

  // data only changes on a load, so it is stable while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N stream demultiplexer with per-channel valid/ready holding slots.
// Define STREAM_DEMUX_ERR_EN to add the err port flagging accepted out-of-range selects.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N     = DEMUX_N_DEF,
  parameter int W     = DEMUX_W_DEF,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [W-1:0]     in_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data
`ifdef STREAM_DEMUX_ERR_EN
  ,
  output logic             err
`endif
);

  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic [N-1:0] can_accept;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (in_sel == SEL_W'(i));
    end
  end

  // an out-of-range select matches no channel and is accepted and dropped
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (hit[i]) in_ready = can_accept[i];
    end
  end

  assign load = hit & {N{in_valid & in_ready}};

  for (genvar i = 0; i < N; i++) begin : g_slot
    stream_demux_slot #(.W(W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (load[i]),
      .load_data  (in_data),
      .out_ready  (out_ready[i]),
      .out_valid  (out_valid[i]),
      .out_data   (out_data[i*W +: W]),
      .can_accept (can_accept[i])
    );
  end

`ifdef STREAM_DEMUX_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= in_valid & ~|hit;
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with a per-channel behavioural model checked every cycle.
// Build with STREAM_DEMUX_ERR_EN defined to also check the err output.
module tb_stream_demux;

  localparam int N     = 6;
  localparam int W     = 32;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [W-1:0]     in_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [N*W-1:0]   out_data;
`ifdef STREAM_DEMUX_ERR_EN
  logic             err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demux #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef STREAM_DEMUX_ERR_EN
    ,
    .err       (err)
`endif
  );

  // model: each channel holds at most one word; a word is present or not
  logic         mv [N];
  logic [W-1:0] md [N];
  logic         err_exp;

  function automatic logic model_ready();
    int s;
    s = int'(in_sel);
    if (s >= N) return 1'b1;
    return !mv[s] || out_ready[s];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mv[i] <= 1'b0;
        md[i] <= '0;
      end
      err_exp <= 1'b0;
    end else begin
      logic acc;
      int   s;
      s   = int'(in_sel);
      acc = in_valid && model_ready();
      for (int i = 0; i < N; i++) begin
        if (acc && s == i) begin
          mv[i] <= 1'b1;
          md[i] <= in_data;
        end else if (mv[i] && out_ready[i]) begin
          mv[i] <= 1'b0;
        end
      end
      err_exp <= acc && (s >= N);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ev;
    for (int i = 0; i < N; i++) ev[i] = mv[i];
    chk("cmp_out_valid", 256'(out_valid), 256'(ev));
    if (!reset) chk("cmp_in_ready", 256'(in_ready), 256'(model_ready()));
    for (int i = 0; i < N; i++) begin
      if (mv[i]) chk($sformatf("cmp_out_data%0d", i), 256'(out_data[i*W +: W]), 256'(md[i]));
    end
`ifdef STREAM_DEMUX_ERR_EN
    chk("cmp_err", 256'(err), 256'(err_exp));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ch(input int i);
    return out_data[i*W +: W];
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(6'b000000));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_out_data", 256'(out_data), 256'(0));

    // single load into a stalled channel, then backpressure
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hA5A5_0001;
    #1 chk("ld_in_ready", 256'(in_ready), 256'(1'b1));
    tick();
    in_data = 32'hDEAD_BEEF;
    #1;
    chk("ld_out_valid", 256'(out_valid), 256'(6'b000100));
    chk("ld_data", 256'(ch(2)), 256'(32'hA5A5_0001));
    chk("full_in_ready", 256'(in_ready), 256'(1'b0));
    tick();
    chk("hold_out_valid", 256'(out_valid), 256'(6'b000100));
    chk("hold_data", 256'(ch(2)), 256'(32'hA5A5_0001));

    // back-to-back into the same channel with the consumer ready
    out_ready = 6'b000100;
    in_data = 32'h11;
    #1 chk("bb_ready_11", 256'(in_ready), 256'(1'b1));
    tick();
    chk("bb_data_11", 256'(ch(2)), 256'(32'h11));
    in_data = 32'h22;
    #1 chk("bb_ready_22", 256'(in_ready), 256'(1'b1));
    tick();
    chk("bb_data_22", 256'(ch(2)), 256'(32'h22));
    in_data = 32'h33;
    #1 chk("bb_ready_33", 256'(in_ready), 256'(1'b1));
    tick();
    chk("bb_data_33", 256'(ch(2)), 256'(32'h33));
    chk("bb_valid_33", 256'(out_valid), 256'(6'b000100));
    in_valid = 1'b0;
    tick();
    chk("bb_drained", 256'(out_valid), 256'(6'b000000));

    // a stalled channel does not block another channel
    in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h77;
    tick();
    in_sel = 3'd4; in_data = 32'h88;
    #1 chk("indep_ready", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("indep_valid", 256'(out_valid), 256'(6'b010010));
    chk("indep_ch4", 256'(ch(4)), 256'(32'h88));
    chk("indep_ch1", 256'(ch(1)), 256'(32'h77));

    // out-of-range selects are accepted and dropped
    in_valid = 1'b1; in_sel = 3'd7; in_data = 32'hBAD0_0007;
    #1 chk("ill7_ready", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("ill7_valid", 256'(out_valid), 256'(6'b010010));
`ifdef STREAM_DEMUX_ERR_EN
    chk("ill7_err", 256'(err), 256'(1'b1));
`endif
    tick();
`ifdef STREAM_DEMUX_ERR_EN
    chk("ill7_err_clr", 256'(err), 256'(1'b0));
`endif
    in_valid = 1'b1; in_sel = 3'd6; in_data = 32'hBAD0_0006;
    #1 chk("ill6_ready", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("ill6_valid", 256'(out_valid), 256'(6'b010010));
    chk("ill6_ch4", 256'(ch(4)), 256'(32'h88));

    // fill ch0/ch3/ch5, then reset asynchronously between edges
    in_valid = 1'b1;
    in_sel = 3'd0; in_data = 32'h100; tick();
    in_sel = 3'd3; in_data = 32'h300; tick();
    in_sel = 3'd5; in_data = 32'h500; tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 256'(out_valid), 256'(6'b111011));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 256'(out_valid), 256'(6'b000000));
    chk("async_rst_data", 256'(out_data), 256'(0));
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hC3C3_0003;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("no_load_in_rst", 256'(out_valid), 256'(6'b000000));
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 256'(out_valid), 256'(6'b001000));
    chk("post_rst_data", 256'(ch(3)), 256'(32'hC3C3_0003));

    // mixed traffic checked by the model
    for (int k = 0; k < 60; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 6'($urandom_range(0, 63));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = '1;
    repeat (3) tick();
    chk("final_drained", 256'(out_valid), 256'(6'b000000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
